// File: rtl/ov7670_capture_pkg.sv
// Shared definitions for the OV7670 DVP capture path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, queue word width, SOF bit index, default SOF word.
package ov7670_capture_pkg;

   localparam int QW      = 17;   // queue word: SOF marker + RGB565 pixel
   localparam int SOF_BIT = 16;

   localparam logic [QW-1:0] SOF_WORD_DEF = QW'(1) << SOF_BIT;

   typedef enum logic [2:0] {
      WAIT_CALIB       = 3'd0,
      WAIT_VSYNC_HIGH  = 3'd1,
      WAIT_FRAME_START = 3'd2,
      CAPTURE          = 3'd3,
      DROP_FRAME       = 3'd4
   } state_t;

endpackage

// File: rtl/ov7670_capture_pixel_assembler.sv
// Pairs two registered camera bytes into one RGB565 pixel (first byte = [15:8]).
// Latency: o_vld is combinational in the cycle the second byte sits in the input register.
// Backpressure: none; the caller decides whether a valid pixel is written or dropped.
// Ports: clk/reset_p; i_en gates toggling, i_clr forces the next byte to be a high byte;
//        i_href/i_data are the registered camera inputs; o_pixel/o_vld/o_half out.
module ov7670_pixel_assembler (
   input  logic        clk,
   input  logic        reset_p,
   input  logic        i_en,
   input  logic        i_clr,
   input  logic        i_href,
   input  logic [7:0]  i_data,
   output logic [15:0] o_pixel,
   output logic        o_vld,
   output logic        o_half
);

   logic [7:0] r_hi;
   logic       r_half;

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_hi   <= '0;
         r_half <= 1'b0;
      end else if (i_clr) begin
         r_half <= 1'b0;
      end else if (i_en && i_href) begin
         if (!r_half) r_hi <= i_data;
         r_half <= ~r_half;
      end
   end

   // The low byte is taken straight from the input register so the pixel
   // is complete in the same cycle the second byte arrives.
   assign o_pixel = {r_hi, i_data};
   assign o_vld   = i_en & i_href & r_half;
   assign o_half  = r_half;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 DVP (RGB565, 2 bytes/pixel) to 17-bit queue words; bit16 marks start of frame.
// Latency: 2 clk from the second byte of a pixel at the pins to queue_wr_en.
// Backpressure: queue_full on a due write drops it, sets sticky overflow and skips the rest of the frame.
// Ports: clk/reset_p, enable (calibration done), cam_vsync/href/p_data (camera),
//        queue_full/queue_data/queue_wr_en/queue_clk (FIFO), frame_count/overflow/size_error/clear_status.
module ov7670_capture
   import ov7670_capture_pkg::*;
#(
   parameter int              FRAME_WIDTH  = 640,
   parameter int              FRAME_HEIGHT = 480,
   parameter logic [QW-1:0]   SOF_WORD     = SOF_WORD_DEF
) (
   input  logic          clk,
   input  logic          reset_p,
   input  logic          enable,
   input  logic          cam_vsync,
   input  logic          href,
   input  logic [7:0]    p_data,
   input  logic          queue_full,
   output logic [QW-1:0] queue_data,
   output logic          queue_wr_en,
   output logic          queue_clk,
   output logic [15:0]   frame_count,
   output logic          overflow,
   output logic          size_error,
   input  logic          clear_status
);

   localparam logic [15:0] W16 = 16'(FRAME_WIDTH);
   localparam logic [15:0] H16 = 16'(FRAME_HEIGHT);

   state_t        r_state, w_state_nxt;
   logic          r_vsync, r_vsync_d, r_href, r_href_d;
   logic [7:0]    r_data;
   logic [15:0]   r_pix_cnt, r_line_cnt, r_frame_cnt;
   logic [QW-1:0] r_queue_data, w_dat_nxt;
   logic          r_wr_en, w_wr_nxt;
   logic          r_overflow, r_size_err;

   logic          w_vsync_fall, w_vsync_rise, w_href_fall;
   logic          w_pix_vld, w_half, w_asm_en, w_asm_clr;
   logic [15:0]   w_pixel, w_line_eff;
   logic          w_ovf_set, w_size_set, w_cnt_clr, w_pix_inc, w_line_inc, w_frame_inc, w_drop;

   assign queue_clk = clk;

   // Input stage: one register layer, edges compared against a second copy.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_vsync   <= 1'b0;
         r_vsync_d <= 1'b0;
         r_href    <= 1'b0;
         r_href_d  <= 1'b0;
         r_data    <= '0;
      end else begin
         r_vsync   <= cam_vsync;
         r_vsync_d <= r_vsync;
         r_href    <= href;
         r_href_d  <= r_href;
         r_data    <= p_data;
      end
   end

   assign w_vsync_fall = r_vsync_d & ~r_vsync;
   assign w_vsync_rise = ~r_vsync_d & r_vsync;
   assign w_href_fall  = r_href_d & ~r_href;
   assign w_asm_en     = (r_state == CAPTURE);

   ov7670_pixel_assembler u_asm (
      .clk     (clk),
      .reset_p (reset_p),
      .i_en    (w_asm_en),
      .i_clr   (w_asm_clr),
      .i_href  (r_href),
      .i_data  (r_data),
      .o_pixel (w_pixel),
      .o_vld   (w_pix_vld),
      .o_half  (w_half)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_wr_nxt    = 1'b0;
      w_dat_nxt   = r_queue_data;
      w_ovf_set   = 1'b0;
      w_size_set  = 1'b0;
      w_cnt_clr   = 1'b0;
      w_pix_inc   = 1'b0;
      w_line_inc  = 1'b0;
      w_frame_inc = 1'b0;
      w_drop      = 1'b0;
      w_asm_clr   = 1'b0;
      w_line_eff  = r_line_cnt;
      if (!enable) begin
         w_state_nxt = WAIT_CALIB;
      end else begin
         case (r_state)
            // Starting while vsync is low would mean joining a frame mid-way.
            WAIT_CALIB:      w_state_nxt = r_vsync ? WAIT_FRAME_START : WAIT_VSYNC_HIGH;
            WAIT_VSYNC_HIGH: if (r_vsync) w_state_nxt = WAIT_FRAME_START;
            WAIT_FRAME_START: begin
               if (w_vsync_fall) begin
                  w_cnt_clr = 1'b1;
                  w_asm_clr = 1'b1;
                  if (queue_full) begin
                     w_ovf_set   = 1'b1;
                     w_state_nxt = DROP_FRAME;
                  end else begin
                     w_wr_nxt    = 1'b1;
                     w_dat_nxt   = SOF_WORD;
                     w_state_nxt = CAPTURE;
                  end
               end
            end
            CAPTURE: begin
               if (w_pix_vld) begin
                  if (queue_full) begin
                     w_ovf_set = 1'b1;
                     w_drop    = 1'b1;
                  end else begin
                     w_wr_nxt  = 1'b1;
                     w_dat_nxt = {1'b0, w_pixel};
                     w_pix_inc = 1'b1;
                  end
               end
               if (w_href_fall) begin
                  if (r_pix_cnt != W16 || w_half) w_size_set = 1'b1;
                  w_line_inc = 1'b1;
                  w_asm_clr  = 1'b1;
                  w_line_eff = r_line_cnt + 16'd1;   // frame check sees this line
               end
               if (w_vsync_rise) begin
                  w_state_nxt = WAIT_FRAME_START;
                  if (!w_drop) begin
                     if (w_line_eff != H16) w_size_set = 1'b1;
                     w_frame_inc = 1'b1;
                  end
               end else if (w_drop) begin
                  w_state_nxt = DROP_FRAME;
               end
            end
            DROP_FRAME:      if (w_vsync_rise) w_state_nxt = WAIT_FRAME_START;
            default:         w_state_nxt = WAIT_CALIB;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_state      <= WAIT_CALIB;
         r_wr_en      <= 1'b0;
         r_queue_data <= '0;
         r_pix_cnt    <= '0;
         r_line_cnt   <= '0;
         r_frame_cnt  <= '0;
         r_overflow   <= 1'b0;
         r_size_err   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wr_en      <= w_wr_nxt;
         r_queue_data <= w_dat_nxt;
         if (w_cnt_clr) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
         end else if (w_line_inc) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= w_line_eff;
         end else if (w_pix_inc) begin
            r_pix_cnt  <= r_pix_cnt + 16'd1;
         end
         if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;
         // A new error in the same cycle as clear_status stays set.
         r_overflow <= w_ovf_set  | (r_overflow & ~clear_status);
         r_size_err <= w_size_set | (r_size_err & ~clear_status);
      end
   end

   assign queue_wr_en = r_wr_en;
   assign queue_data  = r_queue_data;
   assign frame_count = r_frame_cnt;
   assign overflow    = r_overflow;
   assign size_error  = r_size_err;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture with a reduced 8x4 frame; scoreboard of expected queue words.
module tb_ov7670_capture;

   localparam int W = 8;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        reset_p, enable, cam_vsync, href, queue_full, clear_status;
   logic [7:0]  p_data;
   logic [16:0] queue_data;
   logic        queue_wr_en, queue_clk, overflow, size_error;
   logic [15:0] frame_count;

   int          total = 0;
   int          bad   = 0;
   logic [16:0] sb[$];
   bit          cap;
   bit          fixed_pat;

   always #5 clk = ~clk;

   ov7670_capture #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
      .clk          (clk),
      .reset_p      (reset_p),
      .enable       (enable),
      .cam_vsync    (cam_vsync),
      .href         (href),
      .p_data       (p_data),
      .queue_full   (queue_full),
      .queue_data   (queue_data),
      .queue_wr_en  (queue_wr_en),
      .queue_clk    (queue_clk),
      .frame_count  (frame_count),
      .overflow     (overflow),
      .size_error   (size_error),
      .clear_status (clear_status)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Every write is compared against the oldest expected word.
   always @(negedge clk) begin
      if (!reset_p && queue_wr_en) begin
         if (sb.size() == 0) check("wr_unexpected", 32'(queue_wr_en), 32'd0);
         else                check("wr_data", 32'(queue_data), 32'(sb.pop_front()));
      end
   end

   // full_byte >= 0 raises queue_full while that byte is on the pins, which
   // lands on the decision cycle of the pixel completed by the byte before it.
   task automatic send_line(input int nbytes, input int full_byte);
      logic [7:0]  d, hi;
      logic [15:0] pix;
      hi = 8'h00;
      for (int b = 0; b < nbytes; b++) begin
         if (fixed_pat) d = b[0] ? 8'hCD : 8'hAB;
         else           d = 8'($urandom) | 8'h01;
         href       = 1'b1;
         p_data     = d;
         queue_full = (b == full_byte);
         if (b[0]) begin
            pix = {hi, d};
            if (cap && (full_byte < 0 || b < full_byte - 1)) sb.push_back({1'b0, pix});
         end else begin
            hi = d;
         end
         tick(1);
      end
      href       = 1'b0;
      queue_full = 1'b0;
      p_data     = 8'h00;
      tick(3);
      if (full_byte >= 0) cap = 1'b0;
   endtask

   task automatic send_frame(input bit c, input int short_l, input int odd_l, input int full_l);
      int nb;
      cap       = c;
      cam_vsync = 1'b1;
      tick(4);
      cam_vsync = 1'b0;
      if (cap) sb.push_back(17'h10000);
      tick(3);
      for (int l = 0; l < H; l++) begin
         nb = 2 * W - ((l == short_l) ? 2 : 0) + ((l == odd_l) ? 1 : 0);
         send_line(nb, (l == full_l) ? 6 : -1);
      end
      cam_vsync = 1'b1;
      tick(4);
   endtask

   task automatic pulse_clear();
      clear_status = 1'b1;
      tick(1);
      clear_status = 1'b0;
   endtask

   initial begin
      reset_p = 1'b1; enable = 1'b0; cam_vsync = 1'b0; href = 1'b0;
      queue_full = 1'b0; clear_status = 1'b0; p_data = 8'h00;
      cap = 1'b0; fixed_pat = 1'b0;
      tick(2);
      check("rst_wr_en", 32'(queue_wr_en), 32'd0);
      check("rst_data",  32'(queue_data), 32'd0);
      check("rst_frames", 32'(frame_count), 32'd0);
      check("rst_ovf",   32'(overflow), 32'd0);
      check("rst_size",  32'(size_error), 32'd0);
      check("queue_clk", 32'(queue_clk), 32'(clk));
      reset_p = 1'b0;
      tick(2);

      // Camera running, not calibrated: nothing may be written.
      send_frame(1'b0, -1, -1, -1);
      check("disabled_frames", 32'(frame_count), 32'd0);

      // Enable mid-frame: wait for the next vsync before capturing.
      cam_vsync = 1'b0;
      tick(3);
      enable = 1'b1;
      cap    = 1'b0;
      send_line(2 * W, -1);
      send_line(2 * W, -1);

      // Clean frame with a fixed byte pattern.
      fixed_pat = 1'b1;
      send_frame(1'b1, -1, -1, -1);
      fixed_pat = 1'b0;
      check("good_frames", 32'(frame_count), 32'd1);
      check("good_size",   32'(size_error), 32'd0);
      check("good_ovf",    32'(overflow), 32'd0);

      // Short line.
      send_frame(1'b1, 1, -1, -1);
      check("short_frames", 32'(frame_count), 32'd2);
      check("short_size",   32'(size_error), 32'd1);
      pulse_clear();
      check("short_clear",  32'(size_error), 32'd0);

      // Odd byte count; following line must still assemble correctly.
      send_frame(1'b1, -1, 2, -1);
      check("odd_frames", 32'(frame_count), 32'd3);
      check("odd_size",   32'(size_error), 32'd1);
      pulse_clear();
      check("odd_clear",  32'(size_error), 32'd0);

      // Queue full for one cycle mid-line: drop rest of the frame.
      send_frame(1'b1, -1, -1, 1);
      check("ovf_flag",   32'(overflow), 32'd1);
      check("ovf_frames", 32'(frame_count), 32'd3);
      check("ovf_size",   32'(size_error), 32'd0);

      // Next frame recovers with SOF; overflow stays sticky.
      send_frame(1'b1, -1, -1, -1);
      check("rec_frames", 32'(frame_count), 32'd4);
      check("rec_ovf",    32'(overflow), 32'd1);

      // Reset during capture, between lines.
      cap = 1'b1;
      cam_vsync = 1'b1;
      tick(4);
      cam_vsync = 1'b0;
      sb.push_back(17'h10000);
      tick(3);
      send_line(2 * W, -1);
      check("pre_rst_data", 32'(queue_data == 17'h0), 32'd0);
      reset_p = 1'b1;
      #1;
      check("arst_wr_en",  32'(queue_wr_en), 32'd0);
      check("arst_data",   32'(queue_data), 32'd0);
      check("arst_frames", 32'(frame_count), 32'd0);
      check("arst_ovf",    32'(overflow), 32'd0);
      check("arst_size",   32'(size_error), 32'd0);
      tick(1);
      reset_p = 1'b0;
      cap = 1'b0;
      for (int l = 1; l < H; l++) send_line(2 * W, -1);
      cam_vsync = 1'b1;
      tick(4);
      check("post_rst_frames", 32'(frame_count), 32'd0);
      send_frame(1'b1, -1, -1, -1);
      check("resume_frames", 32'(frame_count), 32'd1);
      check("resume_size",   32'(size_error), 32'd0);

      tick(5);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
